vmem_access_unit: RTL and testbench
===================================

// Module: vmem_access_unit
// PURPOSE
//  Memory-stage load/store sequencer sitting directly upstream of the data RAM (dmem_ram).
//  - Accepts one scalar or 6-lane vector load/store request per transaction from execute, over a valid/ready handshake.
//  - Drives the RAM's we/VecOp/address/wd ports and captures rd.
//  - Splits non-unit-stride vector accesses into per-lane scalar accesses.
//  - Returns load data or a store acknowledgement to writeback through a second valid/ready handshake.
// PARAMETERS
//  S      32   scalar word width / address width
//  V      192  vector width; LANES = V/S = 6
//  DEPTH  14   RAM depth in words (matches RAM SIZE); bounds limit
// PORTS
//  clk          in   1  system clock; all state on posedge
//  reset        in   1  asynchronous, active-high reset
//  req_valid    in   1  request present
//  req_ready    out  1  unit can accept (high only in IDLE)
//  req_store    in   1  1=store, 0=load
//  req_vec      in   1  1=vector (LANES words), 0=scalar
//  req_addr     in   S  word address of lane 0
//  req_stride   in   S  word stride between lanes (vector only)
//  req_wdata    in   V  store data; scalar uses [S-1:0]
//  resp_valid   out  1  response present
//  resp_ready   in   1  writeback accepts response
//  resp_rdata   out  V  load data; scalar zero-extended; 0 for stores
//  resp_err     out  1  out-of-range access; no RAM access was made
//  mem_we       out  1  to RAM we
//  mem_vecop    out  1  to RAM VecOp
//  mem_addr     out  S  to RAM address
//  mem_wd       out  V  to RAM wd
//  mem_rd       in   V  from RAM rd
// BEHAVIOUR
//  Reset:
//   - state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
//   - mem_we=0; mem_vecop=0; mem_addr=0; mem_wd=0.
//   - Reset mid-transaction aborts at once; mem_we drops asynchronously and no response is issued.
//  All mem_* outputs are registered.
//   - mem_we is 1 only in ACC, and only for stores.
//  RAM timing: RAM writes during clk low and reads during clk high.
//   - One ACC cycle = one RAM access.
//   - rd is sampled at the posedge that ends that ACC cycle.
//  States:
//   IDLE:  req_ready=1. On req_valid, latch request, lane=0, run bounds check:
//     - error            -> RESP, resp_err=1.
//     - scalar           -> ACC, mem_vecop=0, mem_addr=addr.
//     - vector stride==1 -> ACC, mem_vecop=1, one contiguous access (CONTIG).
//     - vector otherwise -> ACC, mem_vecop=0, strided mode, lane 0 at addr.
//   ACC:   one RAM access per cycle.
//     - Scalar/CONTIG: capture mem_rd (scalar: {0,mem_rd[S-1:0]}), then -> RESP.
//     - Strided: lane i uses mem_addr=addr+i*stride and mem_wd[S-1:0]=wdata lane i.
//       Capture mem_rd[S-1:0] into resp_rdata lane i. lane++; after lane LANES-1 -> RESP.
//   RESP:  resp_valid=1; outputs held stable until resp_ready.
//     - On handshake -> IDLE; a new request is accepted next cycle, no same-cycle bypass.
//  Latency (accept edge -> resp_valid):
//   - error: 1 cycle; scalar/CONTIG: 2 cycles; strided: LANES+1 = 7 cycles.
//  Bounds check:
//   - Last address = addr + (LANES-1)*stride, computed at S+4 bits with no wrap.
//   - Scalar uses addr. Error when last >= DEPTH or addr >= DEPTH.
//  Stride rules:
//   - stride 0: load broadcasts word[addr] to all lanes; store ends with lane 5 data in RAM.
//   - Strides that alias earlier lanes: a later lane overwrites an earlier one.
//  Stores return resp_rdata=0 and resp_err=0 unless out of range.
//  resp_ready held high in RESP gives back-to-back throughput of 1 request per (latency+1) cycles.
// STRUCTURE
//  Shared package vmem_pkg:
//   - vmem_state_e {IDLE, ACC, RESP}.
//   - LANES constant.
//   - vmem_req_t struct {store, vec, addr, stride, wdata}.
//  One sub-module: vmem_lane_agu.
//   - Combinational lane address = addr+lane*stride.
//   - Range flag = (last address >= DEPTH).
//  FSM, lane counter and capture registers stay in the top.
// TESTING
//  1. Scalar store addr=3 data=0xDEADBEEF, then scalar load addr=3
//     -> resp_rdata={160'b0,32'hDEADBEEF}, 2-cycle latency each.
//  2. Vector store addr=2 stride=1 words 1..6, then vector load addr=2
//     -> mem_vecop=1 for 1 cycle; rdata lanes = 1..6.
//  3. Vector load addr=0 stride=2 after words[k]=k+0x10
//     -> 6 ACC cycles at addrs 0,2,4,6,8,10; lanes = 0x10,0x12,...,0x1A.
//  4. Vector load addr=9 stride=1 (last=14 >= DEPTH)
//     -> resp_err=1 after 1 cycle, mem_we never asserted, RAM unchanged.
//  5. Stride-0 vector store addr=5, lanes 0xA0..0xA5 -> word[5]=0xA5.
//     Stride-0 load addr=5 -> all lanes 0xA5.
//  6. Strided store with reset asserted at lane 3
//     -> mem_we low immediately; words for lanes 0-2 written, 3-5 untouched.
//     resp_valid=0, req_ready=1 after release; resp_ready held low keeps response stable.

Source files
------------

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types and constants for the vector memory access unit
package vmem_pkg;
  localparam int S = 32;
  localparam int V = 192;
  localparam int LANES = V / S;
  localparam int DEPTH = 14;
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ACC, RESP} vmem_state_e;
  typedef struct packed {
    logic store;
    logic vec;
    logic [S-1:0] addr;
    logic [S-1:0] stride;
    logic [V-1:0] wdata;
  } vmem_req_t;
endpackage

// File: rtl/vmem_lane_agu.sv
// vmem_lane_agu: lane address generator and vector range check
module vmem_lane_agu
  import vmem_pkg::*;
(
  input  logic [S-1:0]  addr,
  input  logic [S-1:0]  stride,
  input  logic [LW-1:0] lane,
  output logic [S-1:0]  lane_addr,
  output logic          range_err
);
  logic [S+3:0] last;
  assign lane_addr = addr + stride * S'(lane);
  // widened so a huge stride cannot wrap back into range
  assign last = {4'b0, addr} + {4'b0, stride} * (S+4)'(LANES - 1);
  assign range_err = last >= (S+4)'(DEPTH);
endmodule

// File: rtl/vmem_access_unit.sv
// vmem_access_unit: load/store sequencer in front of the data RAM, splitting strided
// vector accesses into per-lane scalar accesses
module vmem_access_unit
  import vmem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_store,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [S-1:0] req_stride,
  input  logic [V-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [V-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic         mem_vecop,
  output logic [S-1:0] mem_addr,
  output logic [V-1:0] mem_wd,
  input  logic [V-1:0] mem_rd
);
  vmem_state_e state, state_n;
  vmem_req_t req_q;
  logic [LW-1:0] lane, lane_n, agu_lane;
  logic [S-1:0] agu_addr, agu_stride, lane_addr;
  logic [V-1:0] wd_shift;
  logic range_err, err_in, contig_in, strided, last_acc;
  // the AGU checks the incoming request in IDLE and walks the latched one in ACC
  assign agu_addr = (state == IDLE) ? req_addr : req_q.addr;
  assign agu_stride = (state == IDLE) ? req_stride : req_q.stride;
  assign lane_n = lane + 1'b1;
  assign agu_lane = (state == IDLE) ? '0 : lane_n;
  vmem_lane_agu agu (
    .addr(agu_addr),
    .stride(agu_stride),
    .lane(agu_lane),
    .lane_addr(lane_addr),
    .range_err(range_err)
  );
  assign err_in = (req_addr >= S'(DEPTH)) || (req_vec && range_err);
  assign contig_in = req_vec && (req_stride == S'(1));
  assign strided = req_q.vec && (req_q.stride != S'(1));
  assign last_acc = !strided || (lane == LW'(LANES - 1));
  assign wd_shift = req_q.wdata >> (S * int'(lane_n));
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = req_valid ? (err_in ? RESP : ACC) : IDLE;
      ACC: state_n = last_acc ? RESP : ACC;
      RESP: state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_q <= '0;
      lane <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      mem_we <= 1'b0;
      mem_vecop <= 1'b0;
      mem_addr <= '0;
      mem_wd <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        req_q <= '{req_store, req_vec, req_addr, req_stride, req_wdata};
        lane <= '0;
        resp_rdata <= '0;
        resp_err <= err_in;
        mem_we <= !err_in && req_store;
        mem_vecop <= !err_in && contig_in;
        mem_addr <= lane_addr;
        mem_wd <= contig_in ? req_wdata : V'(req_wdata[S-1:0]);
      end
      if (state == ACC) begin
        if (!req_q.store) begin
          if (strided) resp_rdata[int'(lane)*S +: S] <= mem_rd[S-1:0];
          else resp_rdata <= req_q.vec ? mem_rd : V'(mem_rd[S-1:0]);
        end
        lane <= lane_n;
        if (last_acc) begin
          mem_we <= 1'b0;
          mem_vecop <= 1'b0;
        end else begin
          mem_addr <= lane_addr;
          mem_wd <= V'(wd_shift[S-1:0]);
        end
      end
    end
  end
endmodule

// File: tb/tb_vmem_access_unit.sv
// tb_vmem_access_unit: directed and random checks against a word-array reference model
module tb_vmem_access_unit;
  import vmem_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_store = 1'b0, req_vec = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_stride = '0;
  logic [191:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we, mem_vecop;
  logic [31:0] mem_addr;
  logic [191:0] resp_rdata, mem_wd, mem_rd;
  logic [31:0] ram [0:13];
  logic [31:0] model [0:13];
  logic [31:0] acc_q [$];
  int we_cnt = 0, vec_cnt = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  vmem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_vec(req_vec), .req_addr(req_addr),
    .req_stride(req_stride), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_vecop(mem_vecop), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // data RAM: writes while clk is low, combinational read
  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_vecop) begin
        for (int i = 0; i < 6; i++)
          if (mem_addr + 32'(i) < 32'd14) ram[int'(mem_addr) + i] <= mem_wd[i*32 +: 32];
      end else if (mem_addr < 32'd14) ram[int'(mem_addr)] <= mem_wd[31:0];
    end
  end

  always_comb begin
    mem_rd = '0;
    if (mem_vecop) begin
      for (int i = 0; i < 6; i++)
        if (mem_addr + 32'(i) < 32'd14) mem_rd[i*32 +: 32] = ram[int'(mem_addr) + i];
    end else if (mem_addr < 32'd14) mem_rd[31:0] = ram[int'(mem_addr)];
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt++;
    if (mem_vecop) vec_cnt++;
    if (!reset && !req_ready && !resp_valid) acc_q.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input bit st, input bit vc, input logic [31:0] a,
                     input logic [31:0] s, input logic [191:0] wd, input int hold);
    logic [35:0] last;
    logic [191:0] exp, snap;
    bit err;
    int lat, exp_lat, we0, vc0, idx;
    last = 36'(a) + 36'(s) * 36'd5;
    err = (a >= 32'd14) || (vc && last >= 36'd14);
    exp = '0;
    exp_lat = err ? 1 : (!vc || s == 32'd1) ? 2 : 7;
    if (!err)
      for (int i = 0; i < (vc ? 6 : 1); i++) begin
        idx = int'(a) + i * int'(s);
        if (st) model[idx] = wd[i*32 +: 32];
        else exp[i*32 +: 32] = model[idx];
      end
    @(negedge clk);
    req_store = st; req_vec = vc; req_addr = a; req_stride = s; req_wdata = wd;
    req_valid = 1'b1;
    chk({tag, " req_ready"}, 192'(req_ready), 192'(1));
    we0 = we_cnt; vc0 = vec_cnt; acc_q.delete();
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1 lat++;
    end
    chk({tag, " latency"}, 192'(lat), 192'(exp_lat));
    chk({tag, " resp_err"}, 192'(resp_err), 192'(err));
    chk({tag, " resp_rdata"}, resp_rdata, exp);
    chk({tag, " we_cycles"}, 192'(we_cnt - we0), 192'((st && !err) ? exp_lat - 1 : 0));
    chk({tag, " vecop_cycles"}, 192'(vec_cnt - vc0), 192'((vc && s == 32'd1 && !err) ? 1 : 0));
    chk({tag, " acc_cycles"}, 192'(acc_q.size()), 192'(exp_lat - 1));
    if (hold > 0) begin
      snap = resp_rdata;
      repeat (hold) @(posedge clk);
      #1 chk({tag, " held valid"}, 192'(resp_valid), 192'(1));
      chk({tag, " held rdata"}, resp_rdata, snap);
    end
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    chk({tag, " done valid"}, 192'(resp_valid), 192'(0));
    chk({tag, " done ready"}, 192'(req_ready), 192'(1));
  endtask

  initial begin
    logic [191:0] wd;
    for (int k = 0; k < 14; k++) begin
      ram[k] = 32'(k + 16);
      model[k] = 32'(k + 16);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 192'(req_ready), 192'(1));
    chk("rst resp_valid", 192'(resp_valid), 192'(0));
    chk("rst resp_err", 192'(resp_err), 192'(0));
    chk("rst resp_rdata", resp_rdata, 192'(0));
    chk("rst mem_we", 192'(mem_we), 192'(0));
    chk("rst mem_vecop", 192'(mem_vecop), 192'(0));
    chk("rst mem_addr", 192'(mem_addr), 192'(0));
    chk("rst mem_wd", mem_wd, 192'(0));
    @(negedge clk) reset = 1'b0;

    run("stride2 load", 0, 1, 0, 2, '0, 0);
    for (int i = 0; i < 6; i++)
      chk("stride2 addr", 192'(acc_q.size() > i ? acc_q[i] : 32'hFFFF_FFFF), 192'(2 * i));
    run("scalar store", 1, 0, 3, 0, 192'h0000_0001_DEAD_BEEF, 0);
    run("scalar load", 0, 0, 3, 0, '0, 2);
    run("contig store", 1, 1, 2, 1, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 0);
    run("contig load", 0, 1, 2, 1, '0, 1);
    run("range err", 0, 1, 9, 1, '0, 0);
    run("range err st", 1, 1, 9, 1, {6{32'h5555_5555}}, 0);
    run("scalar oob", 1, 0, 14, 0, 192'h77, 0);
    run("huge stride", 1, 1, 0, 32'h4000_0000, {6{32'h6666_6666}}, 0);
    run("stride0 store", 1, 1, 5, 0, {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);
    chk("stride0 word5", 192'(ram[5]), 192'(32'hA5));
    run("stride0 load", 0, 1, 5, 0, '0, 0);

    for (int n = 0; n < 40; n++) begin
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run("random", 1'($urandom), 1'($urandom), 32'($urandom_range(0, 15)),
          ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3)),
          wd, int'($urandom_range(0, 2)));
    end

    // strided store aborted by reset while lane 3 is in flight
    for (int i = 0; i < 3; i++) model[1 + 2 * i] = 32'h50 + 32'(i);
    @(negedge clk);
    req_store = 1'b1; req_vec = 1'b1; req_addr = 32'd1; req_stride = 32'd2;
    req_wdata = {32'h55, 32'h54, 32'h53, 32'h52, 32'h51, 32'h50};
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("abort we before", 192'(mem_we), 192'(1));
    chk("abort addr lane3", 192'(mem_addr), 192'(7));
    reset = 1'b1;
    #1 chk("abort we async", 192'(mem_we), 192'(0));
    chk("abort ready", 192'(req_ready), 192'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk("abort resp_valid", 192'(resp_valid), 192'(0));
    chk("abort req_ready", 192'(req_ready), 192'(1));
    chk("abort rdata", resp_rdata, 192'(0));
    run("post abort load", 0, 1, 1, 2, '0, 1);

    for (int k = 0; k < 14; k++) chk($sformatf("ram[%0d]", k), 192'(ram[k]), 192'(model[k]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
